mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Shares one combinational 24x24 mantissa multiplier (`Radix4BoothMultiplier`) between `N_REQ` FP32 multiply lanes of the matrix multiplier. A round-robin arbiter picks one requester per cycle and feeds a 2-stage registered pipeline around the multiplier. Each 48-bit product is returned tagged with the requester ID over a valid/ready response port with backpressure. Requesters supply extended mantissas with the hidden bit already applied; sign, exponent and rounding are handled outside this block.

## Interface
- `N_REQ`, default 4: number of requesters, valid range 1..16.
- `ID_W`, default `$clog2(N_REQ)` (minimum 1): width of the requester ID.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: per-requester operand valid.
- `req_ready` out N_REQ: per-requester accept; at most one bit is high in any cycle.
- `req_a` in N_REQ*24: operand A; lane i occupies bits [24i+23:24i].
- `req_b` in N_REQ*24: operand B, packed the same way as `req_a`.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: consumer accepts the product.
- `rsp_id` out ID_W: index of the requester that issued the product.
- `rsp_product` out 48: unsigned product A*B.
- `busy` out 1: high when any pipeline stage holds an operation (`s1_v | s2_v`).

## Operation
- Pipeline registers:
  - S1 holds {a, b, id, s1_v}.
  - The multiplier sits combinationally between S1 and S2.
  - S2 holds {product, id, s2_v}. S2 drives the `rsp_*` outputs directly.
- Advance rules:
  - `s2_adv = s1_v & (~s2_v | rsp_ready)`.
  - `s1_load = ~s1_v | s2_adv`.
- Arbitration:
  - The search starts at `rr_ptr`, wraps modulo N_REQ, and grants the first index with `req_valid` high.
  - `req_ready[g] = grant[g] & s1_load`.
  - An accept is `req_valid[g] & req_ready[g]`. On an accept, `rr_ptr <= (g+1) mod N_REQ`; otherwise `rr_ptr` holds.
- Handshake rules:
  - `req_ready` may depend combinationally on `req_valid`.
  - `req_valid` must not depend on `req_ready`.
  - Once a requester asserts valid, its operands stay stable until accepted.
- Stall:
  - While `rsp_valid & ~rsp_ready`, `rsp_product` and `rsp_id` hold stable.
  - S1 holds if S2 cannot drain.
  - When both stages are full and `rsp_ready` is low, all `req_ready` bits are 0.
- Arithmetic: `rsp_product = a*b` over the full 48 bits, unsigned, with no truncation.
- Reset values:
  - `s1_v = s2_v = 0`, `rr_ptr = 0`.
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_product = 0`, `busy = 0`.
  - `req_ready` is forced to all zeros while `rst` is high.
- Reset asserted mid-operation discards in-flight operations. No response is produced for them.
- N_REQ=1: the arbiter degenerates to a pass-through. `rr_ptr` stays 0 and `rsp_id` stays 0.

## Timing
- Latency: an accept at edge k loads S1. S2 loads at edge k+1, so `rsp_valid` is high during the cycle after edge k+1, i.e. 2 cycles after the accept.
- Throughput: one accept per cycle while `rsp_ready` stays high.
- Simultaneous events:
  - The S2 drain, the S1-to-S2 advance and a new accept all happen in the same cycle.
  - When `rsp_ready` rises again after a stall, the held product retires that cycle and S1 moves up at the same edge.
- No combinational path from `rsp_ready` to `rsp_valid`.
- There is a combinational path from `rsp_ready` to `req_ready`; it is at most one level of stall logic plus the arbiter.

## Structure
- Package `mul_share_pkg` holds:
  - `MANT_W = 24`, `PROD_W = 48`.
  - The packed struct for the S1 stage.
  - The function `id_w(n)`.
- Sub-module `rr_arbiter` provides the round-robin grant. Its ports are `req[N]`, `ptr[ID_W]`, `grant[N]` and `grant_idx[ID_W]`; it is purely combinational and `rr_ptr` lives in the parent.
- The existing `Radix4BoothMultiplier` is instantiated unchanged between S1 and S2.

## Test plan
- Single op: lane 0 sends a=0x800000, b=0x800000 with `rsp_ready`=1. Expect `rsp_product`=0x400000000000, `rsp_id`=0, `rsp_valid` high exactly 2 cycles after the accept.
- Round robin: all 4 lanes valid continuously, with lane i sending a=0xA00000 (10.0) and b=0xA00000+i, `rsp_ready`=1. Expect accepts in order 0,1,2,3,0,... at one per cycle, and lane 0's product = 0x640000000000.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while lanes 1 and 2 are valid. Expect exactly 2 accepts then all `req_ready`=0, and `rsp_product`/`rsp_id` stable throughout. Release `rsp_ready`: expect both responses on consecutive cycles with no loss or duplication.
- Extreme operands: a=0xFFFFFF, b=0xFFFFFF gives 0xFFFFFE000001. a=0x000000, b=0xFFFFFF gives 0.
- Reset mid-flight: assert `rst` for 1 cycle with S1 and S2 full. Expect `rsp_valid`=0, `busy`=0, and `rr_ptr`=0, so the next grant goes to lane 0 when all lanes are valid.
- Random soak: 10k random operands with random valid/ready. The scoreboard checks every product against a*b and per-lane ordering, and checks that no lane waits more than N_REQ accepts while valid.

Source files
------------

// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared constants, the S1 pipeline-stage struct and the
// ID-width helper for mul_share_arbiter and its sub-blocks.
//   MANT_W   - extended mantissa width, hidden bit included
//   PROD_W   - full unsigned product width
//   MAX_ID_W - widest requester ID supported (16 requesters)
package mul_share_pkg;

  localparam int MANT_W   = 24;
  localparam int PROD_W   = 48;
  localparam int MAX_ID_W = 4;

  // S1 stage contents. The ID field is sized for the largest supported
  // requester count; the top keeps only the low ID_W bits of it.
  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
    logic [MANT_W-1:0]   a;
    logic [MANT_W-1:0]   b;
  } s1_t;

  // Requester ID width; a single requester still needs a 1-bit ID.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_share_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant. The search begins at ptr,
// wraps modulo N and grants the first requesting index.
//   req       - request vector (N bits)
//   ptr       - index with highest priority this cycle (ID_W bits)
//   grant     - one-hot grant, all zero when nothing requests
//   grant_idx - binary index of the grant (0 when nothing requests)
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/radix4_booth_multiplier.sv
// Radix4BoothMultiplier: combinational unsigned MANT_W x MANT_W multiplier
// built from radix-4 Booth partial products.
//   a, b    - unsigned operands (MANT_W bits)
//   product - unsigned a*b (PROD_W bits, no truncation)
module Radix4BoothMultiplier
  import mul_share_pkg::*;
(
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic [PROD_W-1:0] product
);

  // b is zero-extended by two bits so that the top Booth digit is never
  // negative and the operand is treated as unsigned.
  localparam int DIGITS = MANT_W / 2 + 1;
  localparam int ACC_W  = PROD_W + 2;

  logic [2*DIGITS:0]       b_pad;
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] pp;
  logic signed [ACC_W-1:0] acc;
  logic [2:0]              trip;

  assign b_pad = {2'b00, b, 1'b0};
  assign a_ext = {{(ACC_W-MANT_W){1'b0}}, a};

  always_comb begin
    acc  = '0;
    pp   = '0;
    trip = '0;
    for (int i = 0; i < DIGITS; i++) begin
      trip = b_pad[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
  end

  assign product = acc[PROD_W-1:0];

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one combinational 24x24 mantissa multiplier
// between N_REQ requesters through a 2-stage pipeline (S1 operands, S2
// product). Products return in accept order, tagged with the requester ID.
//   clk, rst             - clock, asynchronous active-high reset
//   req_valid/req_ready  - per-requester operand handshake
//   req_a, req_b         - packed operands, lane i at [24i+23:24i]
//   rsp_valid/rsp_ready  - product handshake, driven straight from S2
//   rsp_id, rsp_product  - requester index and unsigned 48-bit product
//   busy                 - any pipeline stage occupied
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready may depend combinationally on valid; valid never waits on
// ready, and a source holds its payload stable from valid until transfer.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*MANT_W-1:0] req_a,
  input  logic [N_REQ*MANT_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    busy
);

  s1_t               s1;
  logic              s2_v;
  logic [ID_W-1:0]   s2_id;
  logic [PROD_W-1:0] s2_prod;
  logic [PROD_W-1:0] mul_p;
  logic [ID_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              s2_adv;
  logic              s1_load;
  logic              accept;

  // S1 moves up when S2 is empty or drains this cycle; S1 can take a new
  // operation when it is empty or moving up.
  assign s2_adv  = s1.v & (~s2_v | rsp_ready);
  assign s1_load = ~s1.v | s2_adv;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = rst ? '0 : (grant & {N_REQ{s1_load}});
  assign accept    = |req_ready;

  Radix4BoothMultiplier u_mul (
    .a       (s1.a),
    .b       (s1.b),
    .product (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      s2_v    <= 1'b0;
      s2_id   <= '0;
      s2_prod <= '0;
      rr_ptr  <= '0;
    end else begin
      if (s2_adv) begin
        s2_v    <= 1'b1;
        s2_id   <= ID_W'(s1.id);
        s2_prod <= mul_p;
      end else if (rsp_ready) begin
        // Drained with nothing behind it; payload kept, only valid drops.
        s2_v <= 1'b0;
      end

      if (s1_load) begin
        s1.v <= accept;
        if (accept) begin
          s1.id <= MAX_ID_W'(grant_idx);
          s1.a  <= req_a[int'(grant_idx)*MANT_W +: MANT_W];
          s1.b  <= req_b[int'(grant_idx)*MANT_W +: MANT_W];
        end
      end

      if (accept) begin
        rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign rsp_valid   = s2_v;
  assign rsp_id      = s2_id;
  assign rsp_product = s2_prod;
  assign busy        = s1.v | s2_v;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed scenarios plus a randomized soak for
// mul_share_arbiter with four requesters. The reference model tracks an
// in-order queue of expected {id, product}, the round-robin pointer, the
// two-deep pipeline occupancy and per-lane waiting counts.
module tb_mul_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*24-1:0] req_a;
  logic [N*24-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [47:0]     rsp_product;
  logic            busy;

  always #5 clk = ~clk;

  mul_share_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- model state / scoreboard ----------------
  logic [N-1:0] pend;
  logic [23:0]  op_a[N];
  logic [23:0]  op_b[N];
  logic         refill;
  logic [51:0]  exp_q[$];      // {id, product} in accept order
  int           acc_edge_q[$]; // edge at which each queued op was accepted
  logic [51:0]  ret_log[$];    // {id, product} seen from the DUT at retire
  int           acc_order[$];
  int           wait_n[N];
  int           edge_n   = 0;
  int           last_ret = -10;
  int           rr_exp   = 0;
  int           n_acc    = 0;
  logic         stalled  = 1'b0;
  logic [47:0]  held_prod;
  logic [IW-1:0] held_id;
  logic [7:0]   v_hist   = '0;

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input logic rdy);
    logic [N-1:0] exp_rdy;
    logic         exp_v;
    int           g;
    int           idx;
    int           t;
    rsp_ready = rdy;
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_a[i*24 +: 24] = op_a[i];
      req_b[i*24 +: 24] = op_b[i];
    end
    #1;
    // Expected grant: first pending lane at or after the pointer.
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr_exp + k) % N;
      if (g < 0 && pend[idx]) g = idx;
    end
    // Room exists unless both stages hold work and the consumer stalls.
    exp_rdy = '0;
    if (g >= 0 && (exp_q.size() < 2 || rdy)) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    // The oldest op reaches the output one edge after its accept, but not
    // before the op ahead of it has retired.
    exp_v = 1'b0;
    if (exp_q.size() > 0) begin
      t = acc_edge_q[0] + 1;
      if (last_ret > t) t = last_ret;
      exp_v = (t <= edge_n);
    end
    check("rsp_valid", rsp_valid, exp_v);
    check("busy", busy, exp_q.size() > 0);
    if (exp_v) begin
      check("rsp_id", rsp_id, exp_q[0][51:48]);
      check("rsp_product", rsp_product, exp_q[0][47:0]);
    end
    if (stalled) begin
      check("hold_product", rsp_product, held_prod);
      check("hold_id", rsp_id, held_id);
    end
    stalled   = rsp_valid & ~rdy;
    held_prod = rsp_product;
    held_id   = rsp_id;
    v_hist    = {v_hist[6:0], rsp_valid};
    if (exp_v && rdy) ret_log.push_back({2'b00, rsp_id, rsp_product});

    @(posedge clk);
    edge_n++;
    if (exp_v && rdy) begin
      void'(exp_q.pop_front());
      void'(acc_edge_q.pop_front());
      last_ret = edge_n;
    end
    if (exp_rdy != '0) begin
      exp_q.push_back({4'(g), 48'(op_a[g]) * 48'(op_b[g])});
      acc_edge_q.push_back(edge_n);
      acc_order.push_back(g);
      n_acc++;
      for (int j = 0; j < N; j++) begin
        if (j != g && pend[j]) begin
          wait_n[j]++;
          check("fairness", wait_n[j] < N, 1'b1);
        end
      end
      wait_n[g] = 0;
      pend[g]   = refill;
      rr_exp    = (g + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst       = 1'b1;
    req_valid = pend;
    rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_product", rsp_product, '0);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_edge_q.delete();
    rr_exp  = 0;
    stalled = 1'b0;
    for (int i = 0; i < N; i++) wait_n[i] = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend != '0 || exp_q.size() != 0) && n < 64) begin
      cycle(1'b1);
      n++;
    end
    check("drain_done", (pend == '0 && exp_q.size() == 0), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int r0;
  int a0;
  int soak_cycles;

  initial begin
    pend      = '0;
    refill    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i]   = '0;
      op_b[i]   = '0;
      wait_n[i] = 0;
    end

    // Reset values, with every lane requesting during reset.
    @(negedge clk);
    pend = '1;
    pulse_reset();
    pend = '0;

    // Single op on lane 0: response visible on the second observation after
    // the accept cycle.
    op_a[0] = 24'h800000;
    op_b[0] = 24'h800000;
    pend[0] = 1'b1;
    r0 = ret_log.size();
    repeat (4) cycle(1'b1);
    check("single_latency", v_hist[3:0], 4'b0010);
    check("single_count", ret_log.size() - r0, 1);
    if (ret_log.size() > r0) begin
      check("single_product", ret_log[r0][47:0], 48'h400000000000);
      check("single_id", ret_log[r0][51:48], 0);
    end

    // Round robin from reset: all lanes continuously valid.
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = 24'hA00000;
      op_b[i] = 24'hA00000 + 24'(i);
    end
    refill = 1'b1;
    pend   = '1;
    acc_order.delete();
    r0 = ret_log.size();
    a0 = n_acc;
    repeat (12) cycle(1'b1);
    check("rr_one_per_cycle", n_acc - a0, 12);
    for (int k = 0; k < 8; k++) begin
      if (k < acc_order.size()) check("rr_order", acc_order[k], k % N);
    end
    refill = 1'b0;
    drain();
    if (ret_log.size() > r0) begin
      check("rr_lane0_product", ret_log[r0][47:0], 48'h640000000000);
      check("rr_lane0_id", ret_log[r0][51:48], 0);
    end

    // Backpressure: lanes 1 and 2 valid, consumer stalled for 5 cycles.
    op_a[1] = 24'($urandom); op_b[1] = 24'($urandom);
    op_a[2] = 24'($urandom); op_b[2] = 24'($urandom);
    pend[1] = 1'b1;
    pend[2] = 1'b1;
    a0 = n_acc;
    repeat (5) cycle(1'b0);
    check("bp_accepts", n_acc - a0, 2);
    r0 = ret_log.size();
    repeat (3) cycle(1'b1);
    check("bp_release_valid", v_hist[2:0], 3'b110);
    check("bp_release_count", ret_log.size() - r0, 2);
    if (ret_log.size() >= r0 + 2)
      check("bp_distinct_ids", ret_log[r0][51:48] != ret_log[r0+1][51:48], 1'b1);

    // Extreme operands.
    op_a[3] = 24'hFFFFFF; op_b[3] = 24'hFFFFFF; pend[3] = 1'b1;
    op_a[1] = 24'h000000; op_b[1] = 24'hFFFFFF; pend[1] = 1'b1;
    r0 = ret_log.size();
    drain();
    check("extreme_count", ret_log.size() - r0, 2);
    for (int k = r0; k < ret_log.size(); k++) begin
      if (ret_log[k][51:48] == 4'd3) check("extreme_max", ret_log[k][47:0], 48'hFFFFFE000001);
      else check("extreme_zero", ret_log[k][47:0], 48'h0);
    end

    // Reset mid-flight with both stages full, pointer away from lane 0.
    refill = 1'b1;
    pend   = '1;
    repeat (3) cycle(1'b0);
    check("full_before_reset", busy, 1'b1);
    pulse_reset();
    a0 = acc_order.size();
    cycle(1'b1);
    check("post_reset_grant", (acc_order.size() > a0) ? acc_order[a0] : -1, 0);
    refill = 1'b0;
    drain();

    // Random soak: 10k accepted operations with random valid and ready.
    soak_cycles = 0;
    a0 = n_acc;
    while (n_acc - a0 < 10000 && soak_cycles < 40000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          op_a[i] = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
          op_b[i] = ($urandom_range(0, 7) == 0) ? 24'h000000 : 24'($urandom);
          pend[i] = 1'b1;
        end
      end
      cycle($urandom_range(0, 3) != 0);
      soak_cycles++;
    end
    check("soak_budget", n_acc - a0 >= 10000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
